flash_sample_reader: RTL and testbench

- Word-by-word audio playback engine for the talking calculator.
- Reads 32-bit words from the flash over an Avalon-MM read master, over an inclusive word-address range.
- Splits each word into two 16-bit samples and presents one sample per sample_tick.
- sample_tick arrives already synchronised to clk as a one-cycle pulse (edge_trap / clockdivider32 path). The audio output stage consumes audio_sample on sample_valid.

---
 rtl/flash_audio_pkg.sv | 22 ++
 rtl/counter.sv | 53 +++++
 rtl/flash_sample_reader.sv | 208 ++++++++++++++++++++
 tb/tb_flash_sample_reader.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash audio playback path.
//   state_t            : playback FSM states
//   FLASH_ADDR_WIDTH   : flash word-address width
//   SAMPLE_WIDTH       : audio sample width (flash word holds two samples)
//   FLASH_MAX_ADDR     : highest flash word address; playback wraps past it to 0
package flash_audio_pkg;

  localparam int unsigned FLASH_ADDR_WIDTH = 23;
  localparam int unsigned SAMPLE_WIDTH     = 16;
  localparam int unsigned FLASH_MAX_ADDR   = 'h7FFFF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    OUT_LO,
    OUT_HI,
    DONE,
    DRAIN
  } state_t;

endpackage

// File: rtl/counter.sv
// Generic loadable up-counter with wrap (or saturate) at MaxVal.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i (takes priority over en_i)
//   load_val_i    : value to load
//   en_i          : advance by Increment
//   count_o       : current count
// When the next step would pass MaxVal the count returns to MinVal, or holds at
// MaxVal if ControlPc is set.
module counter #(
  parameter int unsigned      Width     = 8,
  parameter logic [Width-1:0] Increment = Width'(1),
  parameter logic [Width-1:0] MinVal    = '0,
  parameter logic [Width-1:0] MaxVal    = '1,
  parameter bit               ControlPc = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;
  logic             at_top;

  // Values above MaxVal underflow the subtraction and keep counting up.
  assign at_top = (MaxVal - count_q) < Increment;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      if (at_top) begin
        count_d = ControlPc ? MaxVal : MinVal;
      end else begin
        count_d = count_q + Increment;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/flash_sample_reader.sv
// Word-by-word audio playback engine. Reads 32-bit words from flash over an
// Avalon-MM read master across an inclusive (possibly wrapping) word range and
// emits the low then high 16-bit half of each word, one per sample_tick.
//   clk, reset               : clock, asynchronous active-low reset
//   start, stop              : one-cycle control pulses
//   start_addr, end_addr     : inclusive word range, captured on start
//   sample_tick              : one-cycle sample-rate strobe (already in clk domain)
//   flash_*                  : Avalon-MM read master
//   audio_sample/sample_valid: current sample and its one-cycle update strobe
//   busy, done, underrun     : status (underrun is sticky until reset/start)
module flash_sample_reader
  import flash_audio_pkg::state_t, flash_audio_pkg::IDLE, flash_audio_pkg::REQ,
         flash_audio_pkg::WAIT_DATA, flash_audio_pkg::OUT_LO, flash_audio_pkg::OUT_HI,
         flash_audio_pkg::DONE, flash_audio_pkg::DRAIN;
#(
  parameter int unsigned           ADDR_WIDTH   = flash_audio_pkg::FLASH_ADDR_WIDTH,
  parameter int unsigned           SAMPLE_WIDTH = flash_audio_pkg::SAMPLE_WIDTH,
  parameter int unsigned           DATA_WIDTH   = 2 * SAMPLE_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR     = ADDR_WIDTH'(flash_audio_pkg::FLASH_MAX_ADDR)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH-1:0]   end_addr,
  input  logic                    sample_tick,
  output logic                    flash_read,
  output logic [ADDR_WIDTH-1:0]   flash_address,
  input  logic                    flash_waitrequest,
  input  logic [DATA_WIDTH-1:0]   flash_readdata,
  input  logic                    flash_readdatavalid,
  output logic [SAMPLE_WIDTH-1:0] audio_sample,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    underrun
);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    underrun_q, underrun_d;
  logic                    stop_pend_q, stop_pend_d;
  logic                    addr_load, addr_adv;
  logic                    at_last;
  logic                    tick_ok;

  assign at_last = (cur_addr == last_addr_q);
  // stop beats a coincident tick everywhere
  assign tick_ok = sample_tick && !stop;

  counter #(
    .Width     (ADDR_WIDTH),
    .Increment (ADDR_WIDTH'(1)),
    .MinVal    ('0),
    .MaxVal    (MAX_ADDR),
    .ControlPc (1'b0)
  ) u_addr_cnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (addr_load),
    .load_val_i (start_addr),
    .en_i       (addr_adv),
    .count_o    (cur_addr)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = REQ;
      end
      REQ: begin
        // The request cannot be withdrawn once issued; a stop only redirects
        // the accepted read into DRAIN.
        if (!flash_waitrequest) begin
          state_d = (stop || stop_pend_q) ? DRAIN : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (stop) begin
          state_d = flash_readdatavalid ? IDLE : DRAIN;
        end else if (flash_readdatavalid) begin
          state_d = OUT_LO;
        end
      end
      OUT_LO: begin
        if (stop) begin
          state_d = IDLE;
        end else if (sample_tick) begin
          state_d = OUT_HI;
        end
      end
      OUT_HI: begin
        if (stop) begin
          state_d = IDLE;
        end else if (sample_tick) begin
          state_d = at_last ? DONE : REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (flash_readdatavalid) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    flash_read = (state_q == REQ);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
  end

  // Datapath next state
  always_comb begin
    last_addr_d = last_addr_q;
    word_d      = word_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    underrun_d  = underrun_q;
    stop_pend_d = stop_pend_q;
    addr_load   = 1'b0;
    addr_adv    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_load   = 1'b1;
          last_addr_d = end_addr;
          underrun_d  = 1'b0;
          stop_pend_d = 1'b0;
        end
      end
      REQ: begin
        if (!flash_waitrequest) begin
          stop_pend_d = 1'b0;
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (tick_ok) underrun_d = 1'b1;
      end
      WAIT_DATA: begin
        if (tick_ok) underrun_d = 1'b1;
        if (flash_readdatavalid && !stop) word_d = flash_readdata;
      end
      OUT_LO: begin
        if (tick_ok) begin
          sample_d = word_q[SAMPLE_WIDTH-1:0];
          valid_d  = 1'b1;
        end
      end
      OUT_HI: begin
        if (tick_ok) begin
          sample_d = word_q[DATA_WIDTH-1:SAMPLE_WIDTH];
          valid_d  = 1'b1;
          addr_adv = !at_last;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_addr_q <= '0;
      word_q      <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      underrun_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      last_addr_q <= last_addr_d;
      word_q      <= word_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      underrun_q  <= underrun_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign flash_address = cur_addr;
  assign audio_sample  = sample_q;
  assign sample_valid  = valid_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader with a small Avalon slave model.
module tb_flash_sample_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [22:0] start_addr = '0;
  logic [22:0] end_addr = '0;
  logic        sample_tick = 1'b0;
  logic        flash_read;
  logic [22:0] flash_address;
  logic        flash_waitrequest = 1'b0;
  logic [31:0] flash_readdata = '0;
  logic        flash_readdatavalid = 1'b0;
  logic [15:0] audio_sample;
  logic        sample_valid;
  logic        busy;
  logic        done;
  logic        underrun;

  int total = 0;
  int bad = 0;

  // slave model state
  int          wait_cycles = 0;
  int          rsp_delay = 0;
  int          wcnt = 0;
  int          rsp_cnt = 0;
  bit          acc_pend = 0;
  bit          req_active = 0;
  logic [22:0] acc_addr = '0;
  logic [22:0] req_addr = '0;
  int          rdv_total = 0;
  int          stab_err = 0;
  int          done_cnt = 0;
  logic [22:0] acc_q[$];
  logic [15:0] smp_q[$];

  flash_sample_reader dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .stop                (stop),
    .start_addr          (start_addr),
    .end_addr            (end_addr),
    .sample_tick         (sample_tick),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .audio_sample        (audio_sample),
    .sample_valid        (sample_valid),
    .busy                (busy),
    .done                (done),
    .underrun            (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (a == 23'd5) return 32'hBEEF_1234;
    return {4'hA, a[11:0], 4'h5, a[11:0]};
  endfunction

  // Avalon slave: wait_cycles stall cycles per read, data rsp_delay cycles after accept.
  always @(negedge clk) begin
    flash_readdatavalid = 1'b0;
    if (!reset) begin
      acc_pend = 0; req_active = 0; wcnt = 0; flash_waitrequest = 1'b0;
    end else begin
      if (acc_pend) begin
        if (rsp_cnt == 0) begin
          flash_readdatavalid = 1'b1;
          flash_readdata = mem_word(acc_addr);
          acc_pend = 0;
          rdv_total++;
        end else begin
          rsp_cnt--;
        end
      end
      if (flash_read) begin
        if (!req_active) begin
          req_active = 1; req_addr = flash_address;
        end else if (flash_address !== req_addr) begin
          stab_err++;
        end
        if (wcnt < wait_cycles) begin
          flash_waitrequest = 1'b1; wcnt++;
        end else begin
          flash_waitrequest = 1'b0;
          acc_pend = 1; rsp_cnt = rsp_delay; acc_addr = flash_address;
          acc_q.push_back(flash_address);
          wcnt = 0; req_active = 0;
        end
      end else begin
        if (req_active) stab_err++;  // request dropped before acceptance
        flash_waitrequest = 1'b0; req_active = 0; wcnt = 0;
      end
    end
  end

  // output monitor
  always @(negedge clk) begin
    if (sample_valid) smp_q.push_back(audio_sample);
    if (done) done_cnt++;
  end

  task automatic clear_scoreboard();
    #1;
    acc_q.delete(); smp_q.delete();
    done_cnt = 0; stab_err = 0;
  endtask

  task automatic do_start(input logic [22:0] s, input logic [22:0] e);
    @(negedge clk); start_addr = s; end_addr = e; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_rdv(input string tag);
    int  prev;
    bit  seen;
    prev = rdv_total;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (rdv_total > prev) begin seen = 1; break; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_rdv_timeout: got none want readdatavalid within 60 cycles", tag);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({flash_read, flash_address, audio_sample, sample_valid, busy, done, underrun} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rd=%b addr=%h smp=%h v=%b busy=%b done=%b ur=%b want all 0",
               flash_read, flash_address, audio_sample, sample_valid, busy, done, underrun);
    end
    idle(1);
    reset = 1'b1;
    idle(2);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single_word();
    clear_scoreboard();
    wait_cycles = 0; rsp_delay = 0;
    do_start(23'd5, 23'd5);
    total++;
    if ({flash_read, busy, flash_address} !== {1'b1, 1'b1, 23'd5}) begin
      bad++;
      $display("FAIL single_req: got rd=%b busy=%b addr=%h want rd=1 busy=1 addr=5",
               flash_read, busy, flash_address);
    end
    wait_rdv("single");
    pulse_tick();
    total++;
    if ({sample_valid, audio_sample} !== {1'b1, 16'h1234}) begin
      bad++;
      $display("FAIL single_lo: got v=%b smp=%h want v=1 smp=1234", sample_valid, audio_sample);
    end
    pulse_tick();
    total++;
    if ({done, sample_valid, audio_sample} !== {1'b1, 1'b1, 16'hBEEF}) begin
      bad++;
      $display("FAIL single_hi_done: got done=%b v=%b smp=%h want done=1 v=1 smp=beef",
               done, sample_valid, audio_sample);
    end
    idle(1);
    total++;
    if ({done, busy, sample_valid, audio_sample} !== {1'b0, 1'b0, 1'b0, 16'hBEEF}) begin
      bad++;
      $display("FAIL single_after: got done=%b busy=%b v=%b smp=%h want 0 0 0 beef",
               done, busy, sample_valid, audio_sample);
    end
    total++;
    if (acc_q.size() != 1 || acc_q[0] !== 23'd5 || done_cnt != 1) begin
      bad++;
      $display("FAIL single_reads: got nreads=%0d dones=%0d want nreads=1 addr=5 dones=1",
               acc_q.size(), done_cnt);
    end
  endtask

  task automatic test_range();
    logic [22:0] exp_a[3];
    logic [15:0] exp_s[6];
    exp_a = '{23'd10, 23'd11, 23'd12};
    exp_s = '{16'h500A, 16'hA00A, 16'h500B, 16'hA00B, 16'h500C, 16'hA00C};
    clear_scoreboard();
    wait_cycles = 3; rsp_delay = 0;
    do_start(23'd10, 23'd12);
    for (int w = 0; w < 3; w++) begin
      wait_rdv("range");
      pulse_tick();
      pulse_tick();
    end
    idle(2);
    total++;
    if (acc_q.size() != 3 || smp_q.size() != 6 || done_cnt != 1 || stab_err != 0 || busy !== 1'b0)
    begin
      bad++;
      $display("FAIL range_counts: got reads=%0d smps=%0d dones=%0d stab=%0d busy=%b want 3 6 1 0 0",
               acc_q.size(), smp_q.size(), done_cnt, stab_err, busy);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (acc_q[i] !== exp_a[i]) begin
        bad++; $display("FAIL range_addr%0d: got %h want %h", i, acc_q[i], exp_a[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (smp_q[i] !== exp_s[i]) begin
        bad++; $display("FAIL range_smp%0d: got %h want %h", i, smp_q[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [22:0] exp_a[4];
    logic [15:0] exp_s[8];
    exp_a = '{23'h7FFFE, 23'h7FFFF, 23'h0, 23'h1};
    exp_s = '{16'h5FFE, 16'hAFFE, 16'h5FFF, 16'hAFFF, 16'h5000, 16'hA000, 16'h5001, 16'hA001};
    clear_scoreboard();
    wait_cycles = 0; rsp_delay = 0;
    do_start(23'h7FFFE, 23'd1);
    for (int w = 0; w < 4; w++) begin
      wait_rdv("wrap");
      pulse_tick();
      pulse_tick();
    end
    idle(2);
    total++;
    if (acc_q.size() != 4 || smp_q.size() != 8 || done_cnt != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wrap_counts: got reads=%0d smps=%0d dones=%0d busy=%b want 4 8 1 0",
               acc_q.size(), smp_q.size(), done_cnt, busy);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (acc_q[i] !== exp_a[i]) begin
        bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, acc_q[i], exp_a[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (smp_q[i] !== exp_s[i]) begin
        bad++; $display("FAIL wrap_smp%0d: got %h want %h", i, smp_q[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_underrun();
    clear_scoreboard();
    wait_cycles = 0; rsp_delay = 3;
    do_start(23'd20, 23'd20);
    pulse_tick();  // lands in WAIT_DATA
    total++;
    if ({underrun, sample_valid} !== 2'b10) begin
      bad++;
      $display("FAIL underrun_set: got ur=%b v=%b want ur=1 v=0", underrun, sample_valid);
    end
    wait_rdv("underrun");
    pulse_tick();
    total++;
    if ({sample_valid, audio_sample, underrun} !== {1'b1, 16'h5014, 1'b1}) begin
      bad++;
      $display("FAIL underrun_lo: got v=%b smp=%h ur=%b want v=1 smp=5014 ur=1",
               sample_valid, audio_sample, underrun);
    end
    pulse_tick();
    idle(2);
    total++;
    if ({done_cnt, smp_q.size()} !== {32'd1, 32'd2} || underrun !== 1'b1) begin
      bad++;
      $display("FAIL underrun_finish: got dones=%0d smps=%0d ur=%b want 1 2 1",
               done_cnt, smp_q.size(), underrun);
    end
    do_start(23'd20, 23'd20);
    total++;
    if (underrun !== 1'b0) begin
      bad++; $display("FAIL underrun_clear: got %b want 0", underrun);
    end
    // stop and tick together in OUT_LO: stop wins
    wait_rdv("stop_lo");
    @(negedge clk); stop = 1'b1; sample_tick = 1'b1;
    @(negedge clk); stop = 1'b0; sample_tick = 1'b0;
    total++;
    if ({sample_valid, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL stop_out_lo: got v=%b busy=%b done=%b want 0 0 0", sample_valid, busy, done);
    end
    idle(2);
    total++;
    if (done_cnt != 1 || smp_q.size() != 2) begin
      bad++;
      $display("FAIL stop_out_lo_quiet: got dones=%0d smps=%0d want 1 2", done_cnt, smp_q.size());
    end
  endtask

  task automatic test_stop_stalled_req();
    int rdv0;
    clear_scoreboard();
    wait_cycles = 4; rsp_delay = 0;
    rdv0 = rdv_total;
    do_start(23'd30, 23'd30);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    total++;
    if ({flash_read, busy, flash_address} !== {1'b1, 1'b1, 23'd30}) begin
      bad++;
      $display("FAIL stop_req_held: got rd=%b busy=%b addr=%h want rd=1 busy=1 addr=1e",
               flash_read, busy, flash_address);
    end
    idle(8);
    total++;
    if (acc_q.size() != 1 || rdv_total != rdv0 + 1 || stab_err != 0) begin
      bad++;
      $display("FAIL stop_req_drain: got reads=%0d rdvs=%0d stab=%0d want 1 1 0",
               acc_q.size(), rdv_total - rdv0, stab_err);
    end
    total++;
    if (smp_q.size() != 0 || done_cnt != 0 || busy !== 1'b0 || flash_read !== 1'b0) begin
      bad++;
      $display("FAIL stop_req_quiet: got smps=%0d dones=%0d busy=%b rd=%b want 0 0 0 0",
               smp_q.size(), done_cnt, busy, flash_read);
    end
  endtask

  task automatic test_async_reset();
    clear_scoreboard();
    wait_cycles = 0; rsp_delay = 0;
    do_start(23'd40, 23'd40);
    wait_rdv("areset");
    pulse_tick();  // now in OUT_HI
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    total++;
    if ({flash_read, flash_address, audio_sample, sample_valid, busy, done, underrun} !== '0) begin
      bad++;
      $display("FAIL areset_outputs: got rd=%b addr=%h smp=%h v=%b busy=%b done=%b ur=%b want 0",
               flash_read, flash_address, audio_sample, sample_valid, busy, done, underrun);
    end
    @(negedge clk); reset = 1'b1;
    clear_scoreboard();
    do_start(23'd3, 23'd3);
    total++;
    if ({flash_read, flash_address} !== {1'b1, 23'd3}) begin
      bad++; $display("FAIL areset_restart: got rd=%b addr=%h want 1 3", flash_read, flash_address);
    end
    wait_rdv("areset2");
    pulse_tick();
    pulse_tick();
    idle(2);
    total++;
    if (acc_q.size() != 1 || acc_q[0] !== 23'd3 || smp_q.size() != 2 || done_cnt != 1) begin
      bad++;
      $display("FAIL areset_play: got reads=%0d smps=%0d dones=%0d want 1 2 1",
               acc_q.size(), smp_q.size(), done_cnt);
    end
    total++;
    if ({smp_q[0], smp_q[1]} !== {16'h5003, 16'hA003}) begin
      bad++;
      $display("FAIL areset_smps: got %h %h want 5003 a003", smp_q[0], smp_q[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_range();
    test_wrap();
    test_underrun();
    test_stop_stalled_req();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
